// File: rtl/pcm_up_sequencer_pkg.sv
// Shared rate codes, state encoding and timing defaults for the PCM up-converter sequencer.
package pcm_up_pkg;

    localparam int SAMPLE_W            = 32;
    localparam int DEF_PERIOD          = 128;
    localparam int DEF_MUTE_PERIODS    = 64;
    localparam int DEF_STARTED_TIMEOUT = 16;

    typedef enum logic [1:0] {
        PCM441 = 2'b00,
        PCM882 = 2'b01,
        PCM176 = 2'b10,
        PCM352 = 2'b11
    } rate_e;

    typedef enum logic {
        MUTE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    // Output periods each input sample is held for.
    function automatic logic [3:0] ratio_of(input logic [1:0] ctrl);
        logic [3:0] r;
        case (rate_e'(ctrl))
            PCM441:  r = 4'd8;
            PCM882:  r = 4'd4;
            PCM176:  r = 4'd2;
            PCM352:  r = 4'd1;
            default: r = 4'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pcm_up_sequencer_hold.sv
// One-deep stereo holding register between the PCM receiver and the converter input.
module pcm_up_seq_hold
    import pcm_up_pkg::*;
(
    input  logic                mclk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                load,
    input  logic                drain,
    input  logic [SAMPLE_W-1:0] load_xl,
    input  logic [SAMPLE_W-1:0] load_xr,
    output logic                full,
    output logic [SAMPLE_W-1:0] hold_xl,
    output logic [SAMPLE_W-1:0] hold_xr,
    output logic                overrun
);

    logic                full_q, full_d;
    logic [SAMPLE_W-1:0] xl_q, xl_d;
    logic [SAMPLE_W-1:0] xr_q, xr_d;

    // A drain always hands out the value present before this edge, so a
    // coincident load simply refills the register without counting as overrun.
    always_comb begin
        full_d  = full_q;
        xl_d    = xl_q;
        xr_d    = xr_q;
        overrun = 1'b0;
        if (flush) begin
            full_d = 1'b0;
        end else begin
            if (drain) begin
                full_d = 1'b0;
            end
            if (load) begin
                xl_d    = load_xl;
                xr_d    = load_xr;
                full_d  = 1'b1;
                overrun = full_q & ~drain;
            end
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            xl_q   <= '0;
            xr_q   <= '0;
        end else begin
            full_q <= full_d;
            xl_q   <= xl_d;
            xr_q   <= xr_d;
        end
    end

    assign full    = full_q;
    assign hold_xl = xl_q;
    assign hold_xr = xr_q;

endmodule

// File: rtl/pcm_up_sequencer.sv
// Output-rate scheduler for the tap-ROM/polyphase up-converter.
// Optional start watchdog and err_nostart port: define PCM_UP_SEQ_WDOG_EN.
//
// state | meaning
// MUTE  | starts still issued, captured results forced to zero, counting mute periods
// RUN   | captured converter results passed to out_yl/out_yr
module pcm_up_sequencer
    import pcm_up_pkg::*;
#(
    parameter int PERIOD          = DEF_PERIOD,
    parameter int MUTE_PERIODS    = DEF_MUTE_PERIODS,
    parameter int STARTED_TIMEOUT = DEF_STARTED_TIMEOUT
) (
    input  logic                mclk,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [1:0]          in_ctrl,
    input  logic [SAMPLE_W-1:0] in_xl,
    input  logic [SAMPLE_W-1:0] in_xr,
    output logic                conv_start,
    output logic [1:0]          conv_ctrl,
    output logic [SAMPLE_W-1:0] conv_xl,
    output logic [SAMPLE_W-1:0] conv_xr,
    input  logic                conv_started,
    input  logic [SAMPLE_W-1:0] conv_yl,
    input  logic [SAMPLE_W-1:0] conv_yr,
    output logic                out_valid,
    output logic [SAMPLE_W-1:0] out_yl,
    output logic [SAMPLE_W-1:0] out_yr,
    output logic                muted,
    input  logic                err_clr,
`ifdef PCM_UP_SEQ_WDOG_EN
    output logic                err_nostart,
`endif
    output logic                err_underrun,
    output logic                err_overrun
);

    localparam int PCNT_W = $clog2(PERIOD);
    localparam int MCNT_W = $clog2(MUTE_PERIODS + 1);
    localparam int PH_W   = 3;

    seq_state_e          state_q, state_d;
    logic [PCNT_W-1:0]   period_cnt_q, period_cnt_d;
    logic [PH_W-1:0]     phase_cnt_q, phase_cnt_d;
    logic [MCNT_W-1:0]   mute_cnt_q, mute_cnt_d;
    logic [1:0]          conv_ctrl_q, conv_ctrl_d;
    logic                conv_start_q, conv_start_d;
    logic [SAMPLE_W-1:0] conv_xl_q, conv_xl_d;
    logic [SAMPLE_W-1:0] conv_xr_q, conv_xr_d;
    logic                out_valid_q, out_valid_d;
    logic [SAMPLE_W-1:0] out_yl_q, out_yl_d;
    logic [SAMPLE_W-1:0] out_yr_q, out_yr_d;
    logic                err_underrun_q, err_underrun_d;
    logic                err_overrun_q, err_overrun_d;

    logic                period_last;
    logic                boundary;
    logic                rate_chg;
    logic                wdog_timeout;
    logic                resync;
    logic                underrun_set;
    logic [PH_W-1:0]     phase_last;

    logic                hold_full;
    logic                hold_overrun;
    logic [SAMPLE_W-1:0] hold_xl;
    logic [SAMPLE_W-1:0] hold_xr;

    assign period_last = (period_cnt_q == PCNT_W'(PERIOD - 1));
    assign boundary    = (period_cnt_q == '0) && (phase_cnt_q == '0);
    assign rate_chg    = (in_ctrl != conv_ctrl_q);
    assign resync      = rate_chg | wdog_timeout;
    assign phase_last  = PH_W'(ratio_of(conv_ctrl_q) - 4'd1);

    pcm_up_seq_hold u_hold (
        .mclk    (mclk),
        .reset_n (reset_n),
        .flush   (resync),
        .load    (in_valid & ~resync),
        .drain   (boundary & ~resync),
        .load_xl (in_xl),
        .load_xr (in_xr),
        .full    (hold_full),
        .hold_xl (hold_xl),
        .hold_xr (hold_xr),
        .overrun (hold_overrun)
    );

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        phase_cnt_d  = phase_cnt_q;
        mute_cnt_d   = mute_cnt_q;
        conv_ctrl_d  = conv_ctrl_q;
        conv_start_d = 1'b0;
        conv_xl_d    = conv_xl_q;
        conv_xr_d    = conv_xr_q;
        out_valid_d  = 1'b0;
        out_yl_d     = out_yl_q;
        out_yr_d     = out_yr_q;
        underrun_set = 1'b0;

        if (resync) begin
            // On a watchdog-only resync in_ctrl already equals conv_ctrl.
            state_d      = MUTE;
            conv_ctrl_d  = in_ctrl;
            period_cnt_d = '0;
            phase_cnt_d  = '0;
            mute_cnt_d   = MCNT_W'(MUTE_PERIODS);
            conv_xl_d    = '0;
            conv_xr_d    = '0;
            out_yl_d     = '0;
            out_yr_d     = '0;
        end else begin
            conv_start_d = (period_cnt_q == '0);
            out_valid_d  = period_last;

            if (boundary) begin
                if (hold_full) begin
                    conv_xl_d = hold_xl;
                    conv_xr_d = hold_xr;
                end else begin
                    conv_xl_d    = '0;
                    conv_xr_d    = '0;
                    underrun_set = (state_q == RUN);
                end
            end

            if (period_last) begin
                period_cnt_d = '0;
                phase_cnt_d  = (phase_cnt_q == phase_last) ? '0 : phase_cnt_q + PH_W'(1);
                if (state_q == RUN) begin
                    out_yl_d = conv_yl;
                    out_yr_d = conv_yr;
                end else begin
                    out_yl_d   = '0;
                    out_yr_d   = '0;
                    mute_cnt_d = mute_cnt_q - MCNT_W'(1);
                    if (mute_cnt_d == '0) begin
                        state_d = RUN;
                    end
                end
            end else begin
                period_cnt_d = period_cnt_q + PCNT_W'(1);
            end
        end

        err_underrun_d = (err_underrun_q & ~err_clr) | underrun_set;
        err_overrun_d  = (err_overrun_q & ~err_clr) | hold_overrun;
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= MUTE;
            period_cnt_q   <= '0;
            phase_cnt_q    <= '0;
            mute_cnt_q     <= MCNT_W'(MUTE_PERIODS);
            conv_ctrl_q    <= 2'b00;
            conv_start_q   <= 1'b0;
            conv_xl_q      <= '0;
            conv_xr_q      <= '0;
            out_valid_q    <= 1'b0;
            out_yl_q       <= '0;
            out_yr_q       <= '0;
            err_underrun_q <= 1'b0;
            err_overrun_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            period_cnt_q   <= period_cnt_d;
            phase_cnt_q    <= phase_cnt_d;
            mute_cnt_q     <= mute_cnt_d;
            conv_ctrl_q    <= conv_ctrl_d;
            conv_start_q   <= conv_start_d;
            conv_xl_q      <= conv_xl_d;
            conv_xr_q      <= conv_xr_d;
            out_valid_q    <= out_valid_d;
            out_yl_q       <= out_yl_d;
            out_yr_q       <= out_yr_d;
            err_underrun_q <= err_underrun_d;
            err_overrun_q  <= err_overrun_d;
        end
    end

`ifdef PCM_UP_SEQ_WDOG_EN
    localparam int WCNT_W = $clog2(STARTED_TIMEOUT + 1);

    logic              wd_active_q, wd_active_d;
    logic [WCNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic              err_nostart_q, err_nostart_d;

    // Armed by each start; a rate change abandons the pending acknowledge.
    always_comb begin
        wd_active_d  = wd_active_q;
        wd_cnt_d     = wd_cnt_q;
        wdog_timeout = 1'b0;
        if (conv_start_q) begin
            wd_active_d = 1'b1;
            wd_cnt_d    = WCNT_W'(STARTED_TIMEOUT);
        end else if (wd_active_q) begin
            if (conv_started) begin
                wd_active_d = 1'b0;
            end else if (wd_cnt_q == WCNT_W'(1)) begin
                wdog_timeout = 1'b1;
                wd_active_d  = 1'b0;
            end else begin
                wd_cnt_d = wd_cnt_q - WCNT_W'(1);
            end
        end
        if (rate_chg) begin
            wd_active_d = 1'b0;
        end
        err_nostart_d = (err_nostart_q & ~err_clr) | wdog_timeout;
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            wd_active_q   <= 1'b0;
            wd_cnt_q      <= '0;
            err_nostart_q <= 1'b0;
        end else begin
            wd_active_q   <= wd_active_d;
            wd_cnt_q      <= wd_cnt_d;
            err_nostart_q <= err_nostart_d;
        end
    end

    assign err_nostart = err_nostart_q;
`else
    localparam int unused_started_timeout = STARTED_TIMEOUT;
    logic unused_conv_started;

    assign wdog_timeout        = 1'b0;
    assign unused_conv_started = conv_started;
`endif

    assign conv_start   = conv_start_q;
    assign conv_ctrl    = conv_ctrl_q;
    assign conv_xl      = conv_xl_q;
    assign conv_xr      = conv_xr_q;
    assign out_valid    = out_valid_q;
    assign out_yl       = out_yl_q;
    assign out_yr       = out_yr_q;
    assign muted        = (state_q == MUTE);
    assign err_underrun = err_underrun_q;
    assign err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_pcm_up_sequencer.sv
// Directed bench for pcm_up_sequencer: mute window, hold/drain ratios, underrun, overrun, rate change.
module tb_pcm_up_sequencer;

    logic        mclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_ctrl = 2'b11;
    logic [31:0] in_xl = '0;
    logic [31:0] in_xr = '0;
    logic        conv_start;
    logic [1:0]  conv_ctrl;
    logic [31:0] conv_xl;
    logic [31:0] conv_xr;
    logic        conv_started = 1'b0;
    logic [31:0] conv_yl;
    logic [31:0] conv_yr;
    logic        out_valid;
    logic [31:0] out_yl;
    logic [31:0] out_yr;
    logic        muted;
    logic        err_clr = 1'b0;
    logic        err_underrun;
    logic        err_overrun;

    int checks = 0;
    int failures = 0;

    pcm_up_sequencer dut (
        .mclk         (mclk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ctrl      (in_ctrl),
        .in_xl        (in_xl),
        .in_xr        (in_xr),
        .conv_start   (conv_start),
        .conv_ctrl    (conv_ctrl),
        .conv_xl      (conv_xl),
        .conv_xr      (conv_xr),
        .conv_started (conv_started),
        .conv_yl      (conv_yl),
        .conv_yr      (conv_yr),
        .out_valid    (out_valid),
        .out_yl       (out_yl),
        .out_yr       (out_yr),
        .muted        (muted),
        .err_clr      (err_clr),
        .err_underrun (err_underrun),
        .err_overrun  (err_overrun)
    );

    always #5 mclk = ~mclk;

    // Converter model: result is a fixed transform of the presented sample.
    assign conv_yl = ~conv_xl;
    assign conv_yr = conv_xr ^ 32'h5A5A_5A5A;
    always @(posedge mclk) conv_started <= conv_start;

    function automatic logic [31:0] xl2(input int j);
        return 32'hA000_0000 + 32'(j);
    endfunction

    function automatic logic [31:0] xr2(input int j);
        return 32'h0B00_0000 - 32'(j);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic pulse_in(input logic [31:0] xl, input logic [31:0] xr);
        in_valid = 1'b1;
        in_xl    = xl;
        in_xr    = xr;
        @(negedge mclk);
        in_valid = 1'b0;
    endtask

    // From the start cycle, run to the next out_valid, optionally sending one sample.
    task automatic run_period(input bit send, input logic [31:0] xl, input logic [31:0] xr,
                              input int at, output int cyc);
        cyc = 0;
        do begin
            if (send && cyc == at) begin
                in_valid = 1'b1;
                in_xl    = xl;
                in_xr    = xr;
            end
            @(negedge mclk);
            cyc++;
            in_valid = 1'b0;
        end while (!out_valid && cyc < 300);
    endtask

    task automatic to_boundary();
        int cyc;
        run_period(1'b0, '0, '0, 0, cyc);
        chk("ov_seen", 32'(out_valid), 1);
    endtask

    task automatic skip_periods(input int n);
        for (int k = 0; k < n; k++) begin
            to_boundary();
            @(negedge mclk);
        end
    endtask

    initial begin
        int cyc;
        logic [31:0] ex, exr;
        logic [31:0] a_xl, b_xl, b_xr, c_xl, d_xl;
        a_xl = 32'h1111_0001;
        b_xl = 32'h1111_0002;
        b_xr = 32'h2222_0002;
        c_xl = 32'h1111_0003;
        d_xl = 32'h1111_0004;

        repeat (3) @(negedge mclk);
        chk("rst_start",    32'(conv_start), 0);
        chk("rst_ctrl",     32'(conv_ctrl), 0);
        chk("rst_xl",       conv_xl, 0);
        chk("rst_xr",       conv_xr, 0);
        chk("rst_ovalid",   32'(out_valid), 0);
        chk("rst_yl",       out_yl, 0);
        chk("rst_yr",       out_yr, 0);
        chk("rst_muted",    32'(muted), 1);
        chk("rst_underrun", 32'(err_underrun), 0);
        chk("rst_overrun",  32'(err_overrun), 0);

        // Rate 352.8k presented at reset exit: one resync cycle, then starts.
        reset_n = 1'b1;
        @(negedge mclk);
        chk("rel_ctrl",  32'(conv_ctrl), 3);
        chk("rel_start", 32'(conv_start), 0);
        chk("rel_muted", 32'(muted), 1);
        @(negedge mclk);

        for (int p = 0; p <= 66; p++) begin
            chk($sformatf("t1_start[%0d]", p), 32'(conv_start), 1);
            chk($sformatf("t1_xl[%0d]", p), conv_xl, (p == 0) ? 32'h0 : 32'(p));
            chk($sformatf("t1_muted[%0d]", p), 32'(muted), (p <= 63) ? 1 : 0);
            run_period(1'b1, 32'(p + 1), 32'h8000_0000 | 32'(p), 40, cyc);
            chk($sformatf("t1_spacing[%0d]", p), 32'(cyc), 127);
            ex  = (p <= 63) ? 32'h0 : ~32'(p);
            exr = (p <= 63) ? 32'h0 : ((32'h8000_0000 | 32'(p - 1)) ^ 32'h5A5A_5A5A);
            chk($sformatf("t1_yl[%0d]", p), out_yl, ex);
            chk($sformatf("t1_yr[%0d]", p), out_yr, exr);
            @(negedge mclk);
            chk($sformatf("t1_ovpulse[%0d]", p), 32'(out_valid), 0);
        end
        chk("t1_underrun", 32'(err_underrun), 0);
        chk("t1_overrun",  32'(err_overrun), 0);

        // Mid-period switch 11 -> 01; the coincident in_valid must be dropped.
        repeat (60) @(negedge mclk);
        in_ctrl  = 2'b01;
        in_valid = 1'b1;
        in_xl    = 32'hDEAD_BEEF;
        in_xr    = 32'hFEED_F00D;
        @(negedge mclk);
        in_valid = 1'b0;
        chk("sw_ctrl",   32'(conv_ctrl), 1);
        chk("sw_start",  32'(conv_start), 0);
        chk("sw_ovalid", 32'(out_valid), 0);
        chk("sw_muted",  32'(muted), 1);
        chk("sw_xl",     conv_xl, 0);
        @(negedge mclk);
        chk("sw_restart", 32'(conv_start), 1);
        chk("sw_discard", conv_xl, 0);
        for (int q = 0; q < 3; q++) begin
            chk($sformatf("sw_muted[%0d]", q), 32'(muted), 1);
            run_period(1'b0, '0, '0, 0, cyc);
            chk($sformatf("sw_spacing[%0d]", q), 32'(cyc), 127);
            chk($sformatf("sw_yl[%0d]", q), out_yl, 0);
            chk($sformatf("sw_underrun[%0d]", q), 32'(err_underrun), 0);
            @(negedge mclk);
        end

        // Rate 44.1k: one input per 8 periods, then one omitted sample.
        in_ctrl = 2'b00;
        @(negedge mclk);
        chk("r8_ctrl",  32'(conv_ctrl), 0);
        chk("r8_start", 32'(conv_start), 0);
        @(negedge mclk);
        for (int p = 0; p <= 87; p++) begin
            int jj;
            jj  = p / 8 - 1;
            ex  = (p < 8 || jj == 9) ? 32'h0 : xl2(jj);
            exr = (p < 8 || jj == 9) ? 32'h0 : xr2(jj);
            chk($sformatf("r8_start[%0d]", p), 32'(conv_start), 1);
            chk($sformatf("r8_xl[%0d]", p), conv_xl, ex);
            chk($sformatf("r8_xr[%0d]", p), conv_xr, exr);
            chk($sformatf("r8_muted[%0d]", p), 32'(muted), (p <= 63) ? 1 : 0);
            chk($sformatf("r8_underrun[%0d]", p), 32'(err_underrun), (p >= 80) ? 1 : 0);
            chk($sformatf("r8_overrun[%0d]", p), 32'(err_overrun), 0);
            run_period((p % 8 == 3) && (p / 8 != 9), xl2(p / 8), xr2(p / 8), 20, cyc);
            chk($sformatf("r8_spacing[%0d]", p), 32'(cyc), 127);
            chk($sformatf("r8_yl[%0d]", p), out_yl, (p <= 63) ? 32'h0 : ~ex);
            @(negedge mclk);
        end
        chk("r8_xl_88", conv_xl, xl2(10));

        err_clr = 1'b1;
        @(negedge mclk);
        err_clr = 1'b0;
        chk("clr_underrun", 32'(err_underrun), 0);

        // Two loads in one hold window: second wins, overrun flagged.
        repeat (3) @(negedge mclk);
        pulse_in(a_xl, 32'h2222_0001);
        chk("ovr_first", 32'(err_overrun), 0);
        repeat (9) @(negedge mclk);
        pulse_in(b_xl, b_xr);
        chk("ovr_second", 32'(err_overrun), 1);
        to_boundary();
        @(negedge mclk);
        skip_periods(7);
        chk("ovr_xl",     conv_xl, b_xl);
        chk("ovr_xr",     conv_xr, b_xr);
        chk("ovr_sticky", 32'(err_overrun), 1);
        err_clr = 1'b1;
        @(negedge mclk);
        err_clr = 1'b0;
        chk("clr_overrun", 32'(err_overrun), 0);

        // Load coincident with the drain: old value goes out, new one is kept.
        pulse_in(c_xl, 32'h2222_0003);
        chk("coin_c_overrun", 32'(err_overrun), 0);
        to_boundary();
        @(negedge mclk);
        skip_periods(6);
        to_boundary();
        pulse_in(d_xl, 32'h2222_0004);
        chk("coin_start",   32'(conv_start), 1);
        chk("coin_xl",      conv_xl, c_xl);
        chk("coin_overrun", 32'(err_overrun), 0);
        skip_periods(8);
        chk("coin_next_xl",  conv_xl, d_xl);
        chk("coin_overrun2", 32'(err_overrun), 0);
        chk("coin_underrun", 32'(err_underrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcm_up_sequencer.md
Name: pcm_up_sequencer

Overview:
Schedules the PCM up-converter datapath (tap ROM plus polyphase filter) at the 352.8 kHz output rate, derived from the 45.1584 MHz mclk.
- Accepts one stereo input sample per input-rate strobe and holds it for the correct number of output periods.
- Issues one start per output period and captures the filtered result.
- Mutes and resynchronises cleanly when the source rate changes.
- Sits between the I2S/PCM receiver and the up-converter.

Parameters:
PERIOD, 128, mclk cycles per output sample (45.1584 MHz / 352.8 kHz)
MUTE_PERIODS, 64, output periods forced to zero after reset-exit or a rate change
STARTED_TIMEOUT, 16, mclk cycles allowed between start and started (watchdog only)

Ports:
mclk  in  1  master clock, 45.1584 MHz
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  one-cycle strobe, new input sample on in_xl/in_xr
in_ctrl  in  2  source rate: 00=44.1k, 01=88.2k, 10=176.4k, 11=352.8k
in_xl  in  32  left input sample, signed
in_xr  in  32  right input sample, signed
conv_start  out  1  one-cycle start to up-converter
conv_ctrl  out  2  active rate code to up-converter
conv_xl  out  32  left sample presented to converter
conv_xr  out  32  right sample presented to converter
conv_started  in  1  converter acknowledge (one-cycle pulse)
conv_yl  in  32  converter left result
conv_yr  in  32  converter right result
out_valid  out  1  one-cycle strobe, new output sample
out_yl  out  32  left output sample
out_yr  out  32  right output sample
muted  out  1  high while outputs are forced to zero
err_clr  in  1  clears all sticky error flags
err_underrun  out  1  sticky: no input sample at a phase-0 boundary
err_overrun  out  1  sticky: in_valid while holding register full

Behaviour:
- Reset (async, reset_n low):
  - all outputs 0, except muted=1 and conv_ctrl=00.
  - period_cnt=0, phase_cnt=0, holding register empty, state=MUTE, mute_cnt=MUTE_PERIODS.
- period_cnt counts 0..PERIOD-1 and wraps.
  - At period_cnt==0: conv_start=1 for exactly one cycle.
  - At period_cnt==PERIOD-1: capture conv_yl/conv_yr into out_yl/out_yr (zeros if muted) and pulse out_valid one cycle later.
  - Fixed latency: result of start N appears on out_valid at mclk cycle N*PERIOD+PERIOD.
- Ratio R is derived from conv_ctrl: 00→8, 01→4, 10→2, 11→1.
  - phase_cnt counts 0..R-1 and advances on each period wrap.
- Holding register is one deep and is loaded on in_valid.
  - Phase-0 boundary (period_cnt==0 and phase_cnt==0) with holding full: conv_xl/conv_xr are loaded from it and it is marked empty.
  - Phase-0 boundary with holding empty: conv_xl/conv_xr=0 and err_underrun set. Suppressed while muted.
  - in_valid with holding full and no same-cycle drain: data overwritten, err_overrun set.
  - in_valid in the same cycle as a drain: the drain takes the old value and the new value is stored (no overrun).
- Errors: sticky until err_clr=1. If err_clr and a new error occur in the same cycle, the flag stays set.
- States:
  - MUTE: conv_start still issued, captured outputs forced to 0, muted=1. mute_cnt decrements per period; at 0 → RUN.
  - RUN: normal operation, muted=0.
  - Any state: in_ctrl != conv_ctrl (sampled every cycle) → conv_ctrl<=in_ctrl, period_cnt=0, phase_cnt=0, holding emptied, conv_xl/xr=0, mute_cnt=MUTE_PERIODS, state=MUTE. The in_valid in that cycle is discarded.
- in_ctrl must be stable at least one cycle before the in_valid of a new stream. A toggle and return re-enters MUTE twice; no glitch filter.
- Widths: samples pass unmodified, with no arithmetic.

Optional Feature:
PCM_UP_SEQ_WDOG_EN
- Defined: counts mclk cycles after each conv_start. If conv_started is not seen within STARTED_TIMEOUT cycles:
  - sticky err_nostart (extra 1-bit output port) is set.
  - the sequencer re-enters MUTE as on a rate change, with conv_ctrl unchanged.
- Undefined: conv_started is ignored, and neither the err_nostart port nor the counter exists.

Decomposition:
- Shared package pcm_up_pkg holds:
  - rate codes PCM441/PCM882/PCM176/PCM352.
  - the ratio function ctrl→R.
  - the state enum {MUTE, RUN}.
  - PERIOD default.
- One natural sub-module: pcm_up_seq_hold (one-deep holding register with overrun/drain logic).

Test Plan:
- Reset release, in_ctrl=11, in_valid every 128 cycles with in_xl=i → out_valid every 128 cycles; muted=1 and outputs 0 for 64 periods, then out_yl follows converter model.
- in_ctrl=00, in_valid every 1024 cycles → conv_xl changes once per 8 conv_start pulses; err_underrun=0, err_overrun=0.
- in_ctrl=00, omit one in_valid after MUTE → conv_xl=0 at that phase-0 boundary, err_underrun=1 until err_clr pulse.
- Two in_valid 10 cycles apart within one period → second value presented, err_overrun=1; in_valid coincident with drain → no overrun.
- Switch in_ctrl 11→01 mid-period → period_cnt restarts, conv_ctrl=01 next cycle, muted=1 for 64 periods, no out_valid glitch.
- With PCM_UP_SEQ_WDOG_EN, model never asserts conv_started → err_nostart=1 17 cycles after conv_start, muted=1.
